fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the 4-bit CPU. It sits upstream of the instruction decoder and produces the opcode that the decoder consumes. It owns the 4-bit program counter and fetches 8-bit instruction words from program ROM over a req/ack handshake. Each word is split into a 4-bit opcode (to the decoder's op input) and a 4-bit immediate (to the ALU immediate path), and both are presented with a one-cycle valid strobe.

## Interface
- `RESET_PC`, default 4'h0: PC value loaded on reset.
- `ACK_TIMEOUT`, default 8: number of FETCH cycles without `rom_ack` before a fetch error is raised. Legal range is 1..255.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `run`  in  1: fetch enable. While low, the unit idles between instructions.
- `rom_req`  out  1: ROM read request.
- `rom_addr`  out  4: ROM word address. Registered and stable while `rom_req` is high.
- `rom_ack`  in  1: ROM read acknowledge. `rom_data` is valid in the same cycle.
- `rom_data`  in  8: instruction word. [7:4] is the opcode, [3:0] is the immediate.
- `op_out`  out  4: current opcode, to the decoder.
- `imm_out`  out  4: current immediate.
- `op_valid`  out  1: one-cycle strobe. `op_out`/`imm_out` are a newly issued instruction.
- `jmp_en`  in  1: jump request, sampled only in ISSUE.
- `jmp_addr`  in  4: jump target.
- `pc_out`  out  4: current PC.
- `halted`  out  1: unit stopped on a halt opcode.
- `fetch_err`  out  1: sticky ROM timeout flag.

## Operation
- States: IDLE, FETCH, ISSUE, HALT, ERR.
- Reset values:
  - state IDLE, `pc_out`=`RESET_PC`.
  - `rom_req`=0, `rom_addr`=`RESET_PC`.
  - `op_out`=4'h0 (NOP), `imm_out`=0.
  - `op_valid`=0, `halted`=0, `fetch_err`=0.
  - Timeout counter 0.
- IDLE:
  - `run`=1 → FETCH, with `rom_req`=1 and `rom_addr`=pc.
  - Otherwise stay in IDLE.
- FETCH:
  - `rom_req` and `rom_addr` are held.
  - On `rom_ack`=1: `op_out`←`rom_data[7:4]`, `imm_out`←`rom_data[3:0]`, `rom_req`←0, go to ISSUE.
  - Without ack, the timeout counter increments.
  - When the counter reaches `ACK_TIMEOUT`: go to ERR, `rom_req`←0, `fetch_err`←1.
  - The counter clears on every entry to FETCH.
- ISSUE:
  - `op_valid`=1 for exactly this cycle.
  - pc ← `jmp_en` ? `jmp_addr` : pc+1. Increment is modulo 16, so 4'hF wraps to 4'h0.
  - Next state: `run` ? FETCH (with `rom_addr`=new pc) : IDLE.
  - A jump to the current PC is legal and refetches it.
- ERR: terminal until reset. `rom_req`=0, `op_valid`=0, `fetch_err`=1.
- `op_out`/`imm_out` hold their last value until the next capture.
- `rom_ack` outside FETCH is ignored.
- `jmp_en` outside ISSUE is ignored.
- `run` dropping during FETCH: the request is never withdrawn. The fetch completes, issues, then the unit enters IDLE.

## Timing
- `rom_ack` sampled high at edge N: `op_valid`=1 and new `op_out` during cycle N+1.
- `rom_req` is low in cycle N+1.
- With a zero-wait ROM (ack in the first FETCH cycle), the peak rate is one instruction per 2 cycles.
- `rom_addr` changes only on entry to FETCH. It is never changed while `rom_req`=1.
- `fetch_err` asserts in the cycle after the `ACK_TIMEOUT`-th unacknowledged FETCH cycle.
- Reset mid-operation:
  - `rom_req` and `op_valid` drop immediately, asynchronously.
  - All outputs take their reset values without waiting for a clock edge.
- A ROM must not assert `rom_ack` for an address once the request has dropped. The unit ignores any such late ack.

## Configuration
- Macro: `FETCH_HALT_EN`.
- Defined:
  - Captured opcode 4'hF issues normally, so `op_valid` pulses.
  - ISSUE then goes to HALT instead of FETCH/IDLE.
  - The PC is not advanced, so `pc_out` keeps the halt instruction's address.
  - HALT sets `halted`=1, `rom_req`=0, ignores `run`/`jmp_en`, and is exited only by reset.
- Not defined:
  - 4'hF is an ordinary opcode; the decoder treats it as NOP.
  - HALT state does not exist and `halted` is tied to 0.

## Test plan
- Zero-wait ROM, `run`=1 from reset, ROM[0..2]=8'h35, 8'h07, 8'h12 → `op_valid` every 2nd cycle, (op,imm) = (3,5), (0,7), (1,2); `pc_out` = 1, 2, 3.
- Wrap: `RESET_PC`=4'hF, no jump → fetch address 15 then 0; `pc_out` goes 4'hF→4'h0.
- ROM with 3 wait cycles, and `jmp_en`=1 with `jmp_addr`=4'h9 during ISSUE of the first instruction → next `rom_addr`=9; `op_valid` arrives 1 cycle after each ack.
- `ACK_TIMEOUT`=4, ROM never acks → `fetch_err`=1 after 4 FETCH cycles; `rom_req`=0 and stays so; `rst_n` pulse clears all flags.
- `run` dropped while a fetch is waiting on ack → ack at cycle N still gives `op_valid` at N+1, then IDLE with `rom_req`=0; `rst_n` low mid-FETCH drops `rom_req` with no clock edge.
- With `FETCH_HALT_EN`, ROM[2]=8'hF0 → `op_valid` with op 4'hF, then `halted`=1, `pc_out`=2, no further requests; without the macro, the fetch continues at address 3.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch sequencer: PC, ROM req/ack handshake, 1-cycle op_valid after ack (2 cycles/instr peak); waits on ack, sticky ERR after ACK_TIMEOUT.
// Optional FETCH_HALT_EN: opcode 4'hF issues, then parks in HALT until reset.
module fetch_unit #(
  parameter logic [3:0] RESET_PC    = 4'h0,
  parameter int         ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       rom_req,
  output logic [3:0] rom_addr,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [3:0] op_out,
  output logic [3:0] imm_out,
  output logic       op_valid,
  input  logic       jmp_en,
  input  logic [3:0] jmp_addr,
  output logic [3:0] pc_out,
  output logic       halted,
  output logic       fetch_err
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_ERR, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_ERR} state_t;
`endif

  state_t     state, state_nxt;
  logic [3:0] pc, pc_nxt;
  logic [7:0] tmo_cnt;
  logic       halt_op;
  logic       tmo_hit;

`ifdef FETCH_HALT_EN
  assign halt_op = (op_out == 4'hF);
`else
  assign halt_op = 1'b0;
`endif

  assign pc_nxt  = jmp_en ? jmp_addr : pc + 4'd1;
  assign tmo_hit = (tmo_cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (rom_ack)      state_nxt = S_ISSUE;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      S_ISSUE: begin
`ifdef FETCH_HALT_EN
        if (halt_op)  state_nxt = S_HALT;
        else
`endif
        if (run)      state_nxt = S_FETCH;
        else          state_nxt = S_IDLE;
      end
      S_ERR:   state_nxt = S_ERR;
`ifdef FETCH_HALT_EN
      S_HALT:  state_nxt = S_HALT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flags decode straight from the state flops so reset drops them without a clock.
  always_comb begin
    rom_req   = (state == S_FETCH);
    op_valid  = (state == S_ISSUE);
    fetch_err = (state == S_ERR);
`ifdef FETCH_HALT_EN
    halted    = (state == S_HALT);
`else
    halted    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rom_addr <= RESET_PC;
      op_out   <= 4'h0;
      imm_out  <= 4'h0;
      tmo_cnt  <= 8'd0;
    end else begin
      if (state == S_IDLE && run) begin
        rom_addr <= pc;
        tmo_cnt  <= 8'd0;
      end
      if (state == S_FETCH) begin
        if (rom_ack) begin
          op_out  <= rom_data[7:4];
          imm_out <= rom_data[3:0];
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end
      // A halting instruction keeps its own address in the PC.
      if (state == S_ISSUE && !halt_op) begin
        pc <= pc_nxt;
        if (run) begin
          rom_addr <= pc_nxt;
          tmo_cnt  <= 8'd0;
        end
      end
    end
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed ROM programs, expected issues queued and checked by a monitor.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       rom_req, rom_ack = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [3:0] op_out, imm_out, pc_out;
  logic       op_valid, halted, fetch_err;
  logic       jmp_en = 1'b0;
  logic [3:0] jmp_addr = 4'h0;

  logic       w_run = 1'b0;
  logic       w_req, w_valid, w_halted, w_err;
  logic [3:0] w_addr, w_op, w_imm, w_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(4'h0), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .op_out(op_out), .imm_out(imm_out),
    .op_valid(op_valid), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc_out(pc_out),
    .halted(halted), .fetch_err(fetch_err)
  );

  // Second instance exercises the PC wrap from RESET_PC=4'hF with a zero-wait ROM.
  fetch_unit #(.RESET_PC(4'hF), .ACK_TIMEOUT(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(w_run), .rom_req(w_req), .rom_addr(w_addr),
    .rom_ack(w_req), .rom_data({4'h2, w_addr}), .op_out(w_op), .imm_out(w_imm),
    .op_valid(w_valid), .jmp_en(1'b0), .jmp_addr(4'h0), .pc_out(w_pc),
    .halted(w_halted), .fetch_err(w_err)
  );

  typedef struct { logic [3:0] op; logic [3:0] imm; logic [3:0] pc; logic [3:0] pc_after; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int errors  = 0;
  int exp_gap = 0;

  logic [7:0] mem [16];
  int  wait_cycles = 0;
  bit  never_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] pc, input logic [3:0] pa);
    exp_t e;
    e.op = op; e.imm = imm; e.pc = pc; e.pc_after = pa;
    sb.push_back(e);
  endtask

  // ROM model: ack after wait_cycles request cycles, driven just after the edge.
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rom_req) begin
        if (!never_ack && rcnt >= wait_cycles) begin
          rom_ack  = 1'b1;
          rom_data = mem[rom_addr];
        end else begin
          rom_ack = 1'b0;
        end
        rcnt++;
      end else begin
        rom_ack = 1'b0;
        rcnt    = 0;
      end
    end
  end

  // Monitor: compares every issued instruction against the scoreboard queue.
  initial begin
    int cyc = 0, last_v = -1;
    bit ack_prev = 0, pc_pend = 0, req_prev = 0;
    logic [3:0] pc_exp = 4'h0, addr_prev = 4'h0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ack_prev = 0; pc_pend = 0; req_prev = 0; last_v = -1;
      end else begin
        if (pc_pend) begin
          check("pc_after_issue", 32'(pc_out), 32'(pc_exp));
          pc_pend = 0;
        end
        if (ack_prev || op_valid) check("valid_one_cycle_after_ack", 32'(op_valid), 32'(ack_prev));
        if (req_prev && rom_req) check("rom_addr_stable", 32'(rom_addr), 32'(addr_prev));
        if (op_valid) begin
          if (sb.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_issue: got op %0h imm %0h, expected none", op_out, imm_out);
          end else begin
            e = sb.pop_front();
            check("op_out", 32'(op_out), 32'(e.op));
            check("imm_out", 32'(imm_out), 32'(e.imm));
            check("pc_at_issue", 32'(pc_out), 32'(e.pc));
            pc_pend = 1; pc_exp = e.pc_after;
          end
          if (exp_gap != 0 && last_v >= 0) check("issue_gap", 32'(cyc - last_v), 32'(exp_gap));
          last_v = cyc;
        end
        ack_prev  = rom_ack && rom_req;
        req_prev  = rom_req;
        addr_prev = rom_addr;
      end
    end
  end

  task automatic do_reset();
    run = 1'b0; w_run = 1'b0; jmp_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int c = 0;
    @(negedge clk);
    while (!op_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (!op_valid) begin
      errors++;
      $display("FAIL %s: op_valid got 0 after %0d cycles, expected 1", tag, budget);
    end
  endtask

  initial begin
    int c;
    foreach (mem[i]) mem[i] = 8'h00;
    do_reset();

    // Reset values
    check("rst_rom_req", 32'(rom_req), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_op_out", 32'(op_out), 0);
    check("rst_imm_out", 32'(imm_out), 0);
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    check("rst_pc", 32'(pc_out), 0);
    check("rst_w_pc", 32'(w_pc), 32'hF);
    check("rst_w_addr", 32'(w_addr), 32'hF);

    // Wrap from 4'hF to 4'h0
    w_run = 1'b1;
    c = 0;
    @(negedge clk);
    while (!w_valid && c < 20) begin @(negedge clk); c++; end
    check("wrap_valid_seen", 32'(w_valid), 1);
    check("wrap_imm_first", 32'(w_imm), 32'hF);
    check("wrap_pc_first", 32'(w_pc), 32'hF);
    @(negedge clk);
    check("wrap_pc_after", 32'(w_pc), 0);
    check("wrap_addr_after", 32'(w_addr), 0);
    check("wrap_req_after", 32'(w_req), 1);
    w_run = 1'b0;
    c = 0;
    @(negedge clk);
    while (!w_valid && c < 20) begin @(negedge clk); c++; end
    check("wrap_imm_second", 32'(w_imm), 0);
    check("wrap_pc_second", 32'(w_pc), 0);

    // Zero-wait streaming
    do_reset();
    mem[0] = 8'h35; mem[1] = 8'h07; mem[2] = 8'h12;
    wait_cycles = 0; exp_gap = 2;
    push(4'h3, 4'h5, 4'h0, 4'h1);
    push(4'h0, 4'h7, 4'h1, 4'h2);
    push(4'h1, 4'h2, 4'h2, 4'h3);
    run = 1'b1;
    for (int i = 0; i < 3; i++) wait_valid(20, "stream_valid");
    run = 1'b0;
    repeat (3) @(negedge clk);
    exp_gap = 0;
    check("stream_idle_req", 32'(rom_req), 0);
    check("stream_sb_drained", 32'(sb.size()), 0);

    // 3 wait cycles plus a jump during the first issue
    do_reset();
    mem[0] = 8'h35; mem[9] = 8'h6C;
    wait_cycles = 3;
    push(4'h3, 4'h5, 4'h0, 4'h9);
    push(4'h6, 4'hC, 4'h9, 4'hA);
    run = 1'b1;
    wait_valid(20, "jump_valid_first");
    jmp_en = 1'b1; jmp_addr = 4'h9;
    @(negedge clk);
    jmp_en = 1'b0; jmp_addr = 4'h3;
    check("jump_rom_addr", 32'(rom_addr), 32'h9);
    check("jump_rom_req", 32'(rom_req), 1);
    wait_valid(20, "jump_valid_second");
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("jump_sb_drained", 32'(sb.size()), 0);

    // Ack timeout
    do_reset();
    never_ack = 1'b1;
    run = 1'b1;
    c = 0;
    @(negedge clk);
    while (!rom_req && c < 10) begin @(negedge clk); c++; end
    for (int i = 0; i < 4; i++) begin
      check("tmo_req_held", 32'(rom_req), 1);
      check("tmo_err_low", 32'(fetch_err), 0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check("tmo_err_set", 32'(fetch_err), 1);
      check("tmo_req_low", 32'(rom_req), 0);
      @(negedge clk);
    end
    do_reset();
    never_ack = 1'b0;
    check("tmo_err_cleared", 32'(fetch_err), 0);
    check("tmo_req_cleared", 32'(rom_req), 0);

    // run drops while waiting on ack, then async reset mid-FETCH
    do_reset();
    mem[0] = 8'h35; mem[1] = 8'hA1;
    wait_cycles = 3;
    push(4'h3, 4'h5, 4'h0, 4'h1);
    run = 1'b1;
    @(negedge clk);
    check("drop_req_up", 32'(rom_req), 1);
    run = 1'b0;
    wait_valid(20, "drop_valid");
    repeat (3) begin
      @(negedge clk);
      check("drop_idle_req", 32'(rom_req), 0);
    end
    check("drop_sb_drained", 32'(sb.size()), 0);
    run = 1'b1;
    @(negedge clk);
    check("refetch_req", 32'(rom_req), 1);
    check("refetch_addr", 32'(rom_addr), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(rom_req), 0);
    check("async_rst_valid", 32'(op_valid), 0);
    check("async_rst_op", 32'(op_out), 0);
    check("async_rst_pc", 32'(pc_out), 0);
    check("async_rst_addr", 32'(rom_addr), 0);

    // Opcode 4'hF: halt when enabled, ordinary opcode otherwise
    do_reset();
    mem[0] = 8'h35; mem[1] = 8'h07; mem[2] = 8'hF0; mem[3] = 8'h4A;
    wait_cycles = 0;
    push(4'h3, 4'h5, 4'h0, 4'h1);
    push(4'h0, 4'h7, 4'h1, 4'h2);
`ifdef FETCH_HALT_EN
    push(4'hF, 4'h0, 4'h2, 4'h2);
    run = 1'b1;
    for (int i = 0; i < 3; i++) wait_valid(20, "halt_valid");
    repeat (4) begin
      @(negedge clk);
      check("halt_flag", 32'(halted), 1);
      check("halt_pc", 32'(pc_out), 32'h2);
      check("halt_no_req", 32'(rom_req), 0);
    end
`else
    push(4'hF, 4'h0, 4'h2, 4'h3);
    push(4'h4, 4'hA, 4'h3, 4'h4);
    run = 1'b1;
    for (int i = 0; i < 4; i++) wait_valid(20, "nohalt_valid");
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("nohalt_flag", 32'(halted), 0);
`endif
    check("halt_sb_drained", 32'(sb.size()), 0);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
